// File: rtl/rst_seq.sv
// rst_seq: reset sequencer for the FPGA top.
// Qualifies PLL lock, then releases NCH active-low reset channels in order,
// staggered in time. Lock loss or a soft-reset request pulls every channel
// back low. Lock losses are counted in a saturating counter.
module rst_seq #(
    parameter int NCH         = 3,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_HOLD   = 16,
    parameter int STAGGER     = 8,
    parameter int SOFT_HOLD   = 4,
    parameter int CW          = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           locked,
    input  logic           soft_rst_req,
    output logic [NCH-1:0] rst_n_out,
    output logic           done,
    output logic [CW-1:0]  lock_drop_cnt
);

    // The shared counter must reach the largest terminal value without wrapping.
    localparam int MAX_HOLD_A = (LOCK_HOLD > STAGGER) ? LOCK_HOLD : STAGGER;
    localparam int MAX_HOLD   = (MAX_HOLD_A > SOFT_HOLD) ? MAX_HOLD_A : SOFT_HOLD;
    localparam int CNT_W      = $clog2(MAX_HOLD + 1);

    localparam logic [CNT_W-1:0] LOCK_LAST    = CNT_W'(LOCK_HOLD - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER - 1);
    localparam logic [CNT_W-1:0] SOFT_LAST    = CNT_W'(SOFT_HOLD - 1);

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_STABLE    = 3'd1,
        ST_RELEASE   = 3'd2,
        ST_RUN       = 3'd3,
        ST_SOFT      = 3'd4
    } state_t;

    // Saturating increment for the lock-drop counter: holds at all-ones.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        if (&v) begin
            r = v;
        end else begin
            r = v + CW'(1);
        end
        return r;
    endfunction

    // Synchroniser chains and the delayed soft_s used for edge detection
    logic [SYNC_STAGES-1:0] lock_sync_q, lock_sync_d;
    logic [SYNC_STAGES-1:0] soft_sync_q, soft_sync_d;
    logic                   soft_dly_q, soft_dly_d;

    logic lock_s;
    logic soft_s;
    logic soft_edge;

    // FSM state and registered outputs
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NCH-1:0]   rst_n_out_q, rst_n_out_d;
    logic             done_q, done_d;
    logic [CW-1:0]    drop_cnt_q, drop_cnt_d;

    // Thermometer pattern with one more channel released than now
    logic [NCH-1:0]   rel_next;

    assign lock_s    = lock_sync_q[SYNC_STAGES-1];
    assign soft_s    = soft_sync_q[SYNC_STAGES-1];
    assign soft_edge = soft_s & ~soft_dly_q;

    // Shift the raw asynchronous inputs into their synchroniser chains.
    always_comb begin
        lock_sync_d = {lock_sync_q[SYNC_STAGES-2:0], locked};
        soft_sync_d = {soft_sync_q[SYNC_STAGES-2:0], soft_rst_req};
        soft_dly_d  = soft_s;
    end

    // Synchroniser registers; cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_sync_q <= '0;
            soft_sync_q <= '0;
            soft_dly_q  <= 1'b0;
        end else begin
            lock_sync_q <= lock_sync_d;
            soft_sync_q <= soft_sync_d;
            soft_dly_q  <= soft_dly_d;
        end
    end

    // Next release pattern: channels are released strictly in order 0..NCH-1,
    // so the released set is always a thermometer code; shift one more 1 in.
    always_comb begin
        rel_next    = '0;
        rel_next[0] = 1'b1;
        for (int i = 1; i < NCH; i++) begin
            rel_next[i] = rst_n_out_q[i-1];
        end
    end

    // Next-state and output logic; lock loss overrides everything else.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rst_n_out_d = rst_n_out_q;
        done_d      = done_q;
        drop_cnt_d  = drop_cnt_q;

        if (state_q != ST_WAIT_LOCK && !lock_s) begin
            // Lock lost: re-assert everything and count the drop.
            state_d     = ST_WAIT_LOCK;
            cnt_d       = '0;
            rst_n_out_d = '0;
            done_d      = 1'b0;
            drop_cnt_d  = sat_inc(drop_cnt_q);
        end else begin
            case (state_q)
                ST_WAIT_LOCK: begin
                    rst_n_out_d = '0;
                    done_d      = 1'b0;
                    if (lock_s) begin
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end
                end

                ST_STABLE: begin
                    if (cnt_q == LOCK_LAST) begin
                        // Lock held long enough: release channel 0.
                        rst_n_out_d = rel_next;
                        cnt_d       = '0;
                        if (&rel_next) begin
                            state_d = ST_RUN;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_RELEASE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                ST_RELEASE: begin
                    if (cnt_q == STAGGER_LAST) begin
                        rst_n_out_d = rel_next;
                        cnt_d       = '0;
                        if (&rel_next) begin
                            state_d = ST_RUN;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                ST_RUN: begin
                    // Soft requests are only honoured once fully running.
                    if (soft_edge) begin
                        state_d     = ST_SOFT;
                        rst_n_out_d = '0;
                        done_d      = 1'b0;
                        cnt_d       = '0;
                    end
                end

                ST_SOFT: begin
                    // After the hold, re-run the full lock qualification.
                    if (cnt_q == SOFT_LAST) begin
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                default: begin
                    state_d     = ST_WAIT_LOCK;
                    cnt_d       = '0;
                    rst_n_out_d = '0;
                    done_d      = 1'b0;
                end
            endcase
        end
    end

    // FSM state, counter and output registers; all clear on rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_WAIT_LOCK;
            cnt_q       <= '0;
            rst_n_out_q <= '0;
            done_q      <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rst_n_out_q <= rst_n_out_d;
            done_q      <= done_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign rst_n_out     = rst_n_out_q;
    assign done          = done_q;
    assign lock_drop_cnt = drop_cnt_q;

endmodule
